cmac_bringup_seq: RTL and testbench
===================================

// Module: cmac_bringup_seq
// PURPOSE
//  Consumer of the board power-on reset: sequences CMAC/GT bring-up in the 100 MHz domain.
//  - Pulses the GT reset and waits for powergood.
//  - Holds the core TX/RX resets, then waits for RX alignment.
//  - Enables TX: sends RFI until aligned, normal traffic after.
//  - Retries on timeout; reports link status and counters. Sits inside the timeslave CMAC wrapper.
// PARAMETERS
//  GT_RST_CYCLES    default 1000        cycles gt_reset is held high
//  CORE_RST_CYCLES  default 256         cycles core_tx_reset/core_rx_reset are held high
//  PGOOD_TIMEOUT    default 1_000_000   max cycles in WAIT_PGOOD before a retry
//  ALIGN_TIMEOUT    default 50_000_000  max cycles in WAIT_ALIGN before a retry
//  MAX_RETRY        default 7           number of retries before FAIL
//  DEBOUNCE_CYCLES  default 1024        alignment-loss filter length (CMAC_SEQ_DEBOUNCE_EN only)
// PORTS
//  clk_100          in   1   100 MHz clock; only clock
//  clk_100_rst      in   1   synchronous, active-high reset
//  gt_powergood     in   1   GT powergood; asynchronous, synchronized in block
//  stat_rx_aligned  in   1   CMAC RX aligned; RX-clock domain, synchronized in block
//  gt_reset         out  1   GT reset
//  core_tx_reset    out  1   CMAC TX core reset
//  core_rx_reset    out  1   CMAC RX core reset
//  ctl_tx_enable    out  1   CMAC TX enable
//  ctl_tx_send_rfi  out  1   CMAC TX send remote-fault indication
//  link_up          out  1   high in LINK_UP only
//  seq_fail         out  1   high in FAIL only
//  retry_count      out  4   retries since reset; saturates at 15
//  link_drops       out  16  LINK_UP->WAIT_ALIGN transitions; wraps at 0xFFFF
//  seq_state        out  3   current state encoding, for debug/status
// BEHAVIOUR
//  - Synchronous, active-high reset. Reset values:
//    - gt_reset = core_tx_reset = core_rx_reset = 1
//    - ctl_tx_enable = 0, ctl_tx_send_rfi = 0
//    - link_up = seq_fail = 0, counters = 0, state = GT_RST
//  - Asserting clk_100_rst in any state aborts the sequence and restarts it; counters clear.
//  - Inputs pass a 2-flop synchronizer: 2-cycle latency. All outputs are registered.
//  - A single cycle counter cnt is cleared on every state entry.
//  - States and transitions:
//    - GT_RST: gt_reset = 1, core resets = 1. Exit to WAIT_PGOOD when cnt == GT_RST_CYCLES-1.
//    - WAIT_PGOOD: gt_reset = 0, core resets = 1.
//      - powergood_s = 1 -> CORE_RST.
//      - Else cnt == PGOOD_TIMEOUT-1 -> RETRY.
//    - CORE_RST: core resets = 1. Exit to WAIT_ALIGN when cnt == CORE_RST_CYCLES-1.
//    - WAIT_ALIGN: core resets = 0, ctl_tx_send_rfi = 1, ctl_tx_enable = 0.
//      - aligned_s = 1 -> LINK_UP.
//      - Else cnt == ALIGN_TIMEOUT-1 -> RETRY.
//    - LINK_UP: ctl_tx_enable = 1, ctl_tx_send_rfi = 0, link_up = 1.
//      - Alignment loss -> WAIT_ALIGN, link_drops += 1 (no retry).
//      - powergood_s = 0 -> RETRY; this takes priority over alignment loss in the same cycle.
//    - RETRY: one cycle.
//      - retry_count == MAX_RETRY -> FAIL.
//      - Else retry_count += 1 (saturating) -> GT_RST.
//    - FAIL: all resets = 1, TX outputs = 0, seq_fail = 1. Left only by clk_100_rst.
//  - A timeout and a success condition in the same cycle: success wins.
//  - Counter width is $clog2 of the largest timeout parameter; no wrap occurs before exit.
// CONFIGURATION
//  - CMAC_SEQ_DEBOUNCE_EN defined: LINK_UP treats alignment as lost only when aligned_s stays 0
//    for DEBOUNCE_CYCLES consecutive cycles. The run counter clears on any aligned_s = 1.
//  - Undefined: a single cycle of aligned_s = 0 in LINK_UP counts as alignment loss.
// STRUCTURE
//  - Package cmac_seq_pkg: state enum seq_state_t (3 bits):
//    GT_RST = 0, WAIT_PGOOD = 1, CORE_RST = 2, WAIT_ALIGN = 3, LINK_UP = 4, RETRY = 5, FAIL = 6.
//  - Package also holds the default timing constants.
//  - One sub-module: sync_2ff, a 1-bit two-flop synchronizer with ASYNC_REG attributes,
//    instanced twice.
// TESTING  (bench parameters: GT_RST_CYCLES = 8, CORE_RST_CYCLES = 4, PGOOD_TIMEOUT = 20,
//           ALIGN_TIMEOUT = 30, MAX_RETRY = 2, DEBOUNCE_CYCLES = 5)
//  - Nominal: powergood = 1 from start, aligned = 1 at cycle 40.
//    -> gt_reset falls at cycle 8, link_up = 1 by cycle 43, retry_count = 0.
//  - Powergood never rises.
//    -> Three GT_RST pulses, then seq_fail = 1, retry_count = 2, all resets held high.
//  - Align timeout once, then aligned = 1.
//    -> retry_count = 1, then link_up = 1, ctl_tx_send_rfi = 0, ctl_tx_enable = 1.
//  - In LINK_UP, drop aligned for 1 cycle.
//    -> Without the macro: link_drops = 1, state WAIT_ALIGN.
//    -> With CMAC_SEQ_DEBOUNCE_EN: no change. A 6-cycle drop gives link_drops = 1.
//  - Assert clk_100_rst mid WAIT_ALIGN.
//    -> Next cycle: state GT_RST, gt_reset = 1, counters = 0, ctl_tx_send_rfi = 0.
//  - In LINK_UP, powergood and aligned fall in the same cycle.
//    -> RETRY taken, link_drops unchanged, retry_count = 1.

Source files
------------

// File: rtl/cmac_bringup_seq_pkg.sv
// Shared types and default timing for the CMAC/GT bring-up sequencer.
// State encoding is visible on seq_state, so the values are fixed.
package cmac_seq_pkg;

  typedef enum logic [2:0] {
    GT_RST     = 3'd0,
    WAIT_PGOOD = 3'd1,
    CORE_RST   = 3'd2,
    WAIT_ALIGN = 3'd3,
    LINK_UP    = 3'd4,
    RETRY      = 3'd5,
    FAIL       = 3'd6
  } seq_state_t;

  localparam int DEF_GT_RST_CYCLES   = 1000;
  localparam int DEF_CORE_RST_CYCLES = 256;
  localparam int DEF_PGOOD_TIMEOUT   = 1_000_000;
  localparam int DEF_ALIGN_TIMEOUT   = 50_000_000;
  localparam int DEF_MAX_RETRY       = 7;
  localparam int DEF_DEBOUNCE_CYCLES = 1024;

  typedef struct packed {
    logic gt_reset;
    logic core_reset;
    logic tx_enable;
    logic tx_send_rfi;
    logic link_up;
    logic seq_fail;
  } seq_out_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Output pattern driven while in a given state; RETRY holds everything in reset.
  function automatic seq_out_t state_outputs(input seq_state_t s);
    seq_out_t o;
    o = '0;
    case (s)
      GT_RST, RETRY: begin
        o.gt_reset   = 1'b1;
        o.core_reset = 1'b1;
      end
      WAIT_PGOOD, CORE_RST: o.core_reset = 1'b1;
      WAIT_ALIGN:           o.tx_send_rfi = 1'b1;
      LINK_UP: begin
        o.tx_enable = 1'b1;
        o.link_up   = 1'b1;
      end
      FAIL: begin
        o.gt_reset   = 1'b1;
        o.core_reset = 1'b1;
        o.seq_fail   = 1'b1;
      end
      default: begin
        o.gt_reset   = 1'b1;
        o.core_reset = 1'b1;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/cmac_bringup_seq_sync_2ff.sv
// 1-bit two-flop synchronizer for level signals crossing into clk_100.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  (* ASYNC_REG = "TRUE" *) logic r_meta;
  (* ASYNC_REG = "TRUE" *) logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/cmac_bringup_seq.sv
// CMAC/GT bring-up sequencer: GT reset, powergood wait, core reset, alignment wait, retries.
// Define CMAC_SEQ_DEBOUNCE_EN to filter short alignment drops while the link is up.
module cmac_bringup_seq
  import cmac_seq_pkg::*;
#(
  parameter int GT_RST_CYCLES   = DEF_GT_RST_CYCLES,
  parameter int CORE_RST_CYCLES = DEF_CORE_RST_CYCLES,
  parameter int PGOOD_TIMEOUT   = DEF_PGOOD_TIMEOUT,
  parameter int ALIGN_TIMEOUT   = DEF_ALIGN_TIMEOUT,
  parameter int MAX_RETRY       = DEF_MAX_RETRY,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic        clk_100,
  input  logic        clk_100_rst,
  input  logic        gt_powergood,
  input  logic        stat_rx_aligned,
  output logic        gt_reset,
  output logic        core_tx_reset,
  output logic        core_rx_reset,
  output logic        ctl_tx_enable,
  output logic        ctl_tx_send_rfi,
  output logic        link_up,
  output logic        seq_fail,
  output logic [3:0]  retry_count,
  output logic [15:0] link_drops,
  output logic [2:0]  seq_state
);

  // Sized for the longest interval so a timed state can never wrap before it exits.
  localparam int CNT_MAX = max2(max2(PGOOD_TIMEOUT, ALIGN_TIMEOUT),
                                max2(max2(GT_RST_CYCLES, CORE_RST_CYCLES), DEBOUNCE_CYCLES));
  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] GT_LAST    = CW'(GT_RST_CYCLES - 1);
  localparam logic [CW-1:0] CORE_LAST  = CW'(CORE_RST_CYCLES - 1);
  localparam logic [CW-1:0] PGOOD_LAST = CW'(PGOOD_TIMEOUT - 1);
  localparam logic [CW-1:0] ALIGN_LAST = CW'(ALIGN_TIMEOUT - 1);
  localparam logic [3:0]    RETRY_LIM  = 4'(MAX_RETRY);

  seq_state_t    r_state;
  seq_state_t    w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [3:0]    r_retry;
  logic [3:0]    w_retry_next;
  logic [15:0]   r_drops;
  logic [15:0]   w_drops_next;
  seq_out_t      r_out;
  logic          w_pgood_s;
  logic          w_aligned_s;
  logic          w_align_lost;

  sync_2ff u_sync_pgood (
    .i_clk (clk_100),
    .i_rst (clk_100_rst),
    .i_d   (gt_powergood),
    .o_q   (w_pgood_s)
  );

  sync_2ff u_sync_aligned (
    .i_clk (clk_100),
    .i_rst (clk_100_rst),
    .i_d   (stat_rx_aligned),
    .o_q   (w_aligned_s)
  );

`ifdef CMAC_SEQ_DEBOUNCE_EN
  localparam int            DW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [DW-1:0] r_deb;
  logic [DW-1:0] w_deb_next;

  // Counts consecutive low cycles of aligned_s while up; loss fires on the last one.
  always_comb begin
    w_deb_next   = '0;
    w_align_lost = 1'b0;
    if (r_state == LINK_UP && !w_aligned_s) begin
      if (r_deb == DEB_LAST) begin
        w_align_lost = 1'b1;
      end else begin
        w_deb_next = r_deb + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100) begin
    if (clk_100_rst || w_state_next != LINK_UP) begin
      r_deb <= '0;
    end else begin
      r_deb <= w_deb_next;
    end
  end
`else
  assign w_align_lost = !w_aligned_s;
`endif

  always_comb begin
    w_state_next = r_state;
    w_retry_next = r_retry;
    w_drops_next = r_drops;
    w_cnt_next   = r_cnt + 1'b1;
    case (r_state)
      GT_RST: begin
        if (r_cnt == GT_LAST) w_state_next = WAIT_PGOOD;
      end
      WAIT_PGOOD: begin
        if (w_pgood_s)                w_state_next = CORE_RST;
        else if (r_cnt == PGOOD_LAST) w_state_next = RETRY;
      end
      CORE_RST: begin
        if (r_cnt == CORE_LAST) w_state_next = WAIT_ALIGN;
      end
      WAIT_ALIGN: begin
        if (w_aligned_s)              w_state_next = LINK_UP;
        else if (r_cnt == ALIGN_LAST) w_state_next = RETRY;
      end
      LINK_UP: begin
        // Losing powergood means the GT itself is gone: full retry, not a link drop.
        if (!w_pgood_s) begin
          w_state_next = RETRY;
        end else if (w_align_lost) begin
          w_state_next = WAIT_ALIGN;
          w_drops_next = r_drops + 16'd1;
        end
      end
      RETRY: begin
        if (r_retry == RETRY_LIM) begin
          w_state_next = FAIL;
        end else begin
          if (r_retry != 4'hF) w_retry_next = r_retry + 4'd1;
          w_state_next = GT_RST;
        end
      end
      FAIL: begin
        w_state_next = FAIL;
      end
      default: w_state_next = GT_RST;
    endcase

    if (w_state_next != r_state) begin
      w_cnt_next = '0;
    end else if (r_state == LINK_UP || r_state == FAIL) begin
      w_cnt_next = r_cnt;
    end
  end

  // Outputs are registered from the next state so they line up with seq_state.
  always_ff @(posedge clk_100) begin
    if (clk_100_rst) begin
      r_state <= GT_RST;
      r_cnt   <= '0;
      r_retry <= '0;
      r_drops <= '0;
      r_out   <= state_outputs(GT_RST);
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_retry <= w_retry_next;
      r_drops <= w_drops_next;
      r_out   <= state_outputs(w_state_next);
    end
  end

  assign gt_reset        = r_out.gt_reset;
  assign core_tx_reset   = r_out.core_reset;
  assign core_rx_reset   = r_out.core_reset;
  assign ctl_tx_enable   = r_out.tx_enable;
  assign ctl_tx_send_rfi = r_out.tx_send_rfi;
  assign link_up         = r_out.link_up;
  assign seq_fail        = r_out.seq_fail;
  assign retry_count     = r_retry;
  assign link_drops      = r_drops;
  assign seq_state       = r_state;

endmodule

// File: tb/tb_cmac_bringup_seq.sv
// Scoreboard bench for cmac_bringup_seq: expected state transitions are queued by the
// stimulus and checked by a monitor whenever seq_state changes.
module tb_cmac_bringup_seq;

  localparam logic [2:0] S_GT = 3'd0, S_WP = 3'd1, S_CR = 3'd2, S_WA = 3'd3,
                         S_LU = 3'd4, S_RT = 3'd5, S_FL = 3'd6;

  logic        clk_100 = 1'b0;
  logic        clk_100_rst = 1'b1;
  logic        gt_powergood = 1'b1;
  logic        stat_rx_aligned = 1'b0;
  logic        gt_reset, core_tx_reset, core_rx_reset;
  logic        ctl_tx_enable, ctl_tx_send_rfi, link_up, seq_fail;
  logic [3:0]  retry_count;
  logic [15:0] link_drops;
  logic [2:0]  seq_state;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0]  st;
    logic [3:0]  rc;
    logic [15:0] ld;
    int          at;
  } exp_t;
  exp_t q[$];

  cmac_bringup_seq #(
    .GT_RST_CYCLES   (8),
    .CORE_RST_CYCLES (4),
    .PGOOD_TIMEOUT   (20),
    .ALIGN_TIMEOUT   (30),
    .MAX_RETRY       (2),
    .DEBOUNCE_CYCLES (5)
  ) dut (
    .clk_100         (clk_100),
    .clk_100_rst     (clk_100_rst),
    .gt_powergood    (gt_powergood),
    .stat_rx_aligned (stat_rx_aligned),
    .gt_reset        (gt_reset),
    .core_tx_reset   (core_tx_reset),
    .core_rx_reset   (core_rx_reset),
    .ctl_tx_enable   (ctl_tx_enable),
    .ctl_tx_send_rfi (ctl_tx_send_rfi),
    .link_up         (link_up),
    .seq_fail        (seq_fail),
    .retry_count     (retry_count),
    .link_drops      (link_drops),
    .seq_state       (seq_state)
  );

  always #5 clk_100 = ~clk_100;

  // Cycles since reset release: the value seen at the negedge after the n-th active edge is n.
  always @(posedge clk_100) cyc <= clk_100_rst ? 0 : cyc + 1;

  // {gt_reset, core_tx, core_rx, tx_enable, send_rfi, link_up, seq_fail}
  function automatic logic [6:0] exp_outs(input logic [2:0] s);
    case (s)
      S_GT:    return 7'b1110000;
      S_WP:    return 7'b0110000;
      S_CR:    return 7'b0110000;
      S_WA:    return 7'b0000100;
      S_LU:    return 7'b0001010;
      S_RT:    return 7'b1110000;
      S_FL:    return 7'b1110001;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] act_outs();
    return {gt_reset, core_tx_reset, core_rx_reset, ctl_tx_enable,
            ctl_tx_send_rfi, link_up, seq_fail};
  endfunction

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_tr(input logic [2:0] st, input logic [3:0] rc,
                           input logic [15:0] ld, input int at);
    exp_t e;
    e.st = st; e.rc = rc; e.ld = ld; e.at = at;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 2000) begin
      @(negedge clk_100);
      guard++;
    end
    if (guard >= 2000) check("wait_cyc_timeout", cyc, n);
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() != 0 && guard < 200) begin
      @(negedge clk_100);
      guard++;
    end
    check("queue_drain", q.size(), 0);
  endtask

  // Called at a negedge; holds reset for three edges and checks the reset values.
  task automatic do_reset();
    clk_100_rst = 1'b1;
    @(negedge clk_100);
    check("rst_state", seq_state, S_GT);
    check("rst_outputs", act_outs(), 7'b1110000);
    check("rst_retry_count", retry_count, 0);
    check("rst_link_drops", link_drops, 0);
    repeat (2) @(negedge clk_100);
    clk_100_rst = 1'b0;
  endtask

  initial begin : monitor
    logic [2:0] prev;
    exp_t e;
    prev = S_GT;
    forever begin
      @(negedge clk_100);
      if (seq_state !== prev) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_transition: got state %0d from %0d, expected none (cyc %0d)",
                   seq_state, prev, cyc);
        end else begin
          e = q.pop_front();
          $display("transition state %0d->%0d cyc %0d retry %0d drops %0d",
                   prev, seq_state, cyc, retry_count, link_drops);
          check("state", seq_state, e.st);
          check("retry_count", retry_count, e.rc);
          check("link_drops", link_drops, e.ld);
          check("outputs", act_outs(), exp_outs(e.st));
          if (e.at >= 0) check("cycle", cyc, e.at);
        end
        prev = seq_state;
      end
    end
  end

  initial begin : stimulus
    // Run A: nominal bring-up, alignment drops, then powergood+aligned loss together.
    gt_powergood = 1'b1;
    stat_rx_aligned = 1'b0;
    do_reset();
    expect_tr(S_WP, 0, 0, 8);
    expect_tr(S_CR, 0, 0, 9);
    expect_tr(S_WA, 0, 0, 13);
    expect_tr(S_LU, 0, 0, 43);
    wait_cyc(40);
    stat_rx_aligned = 1'b1;
    wait_cyc(50);
    stat_rx_aligned = 1'b0;
`ifndef CMAC_SEQ_DEBOUNCE_EN
    expect_tr(S_WA, 0, 1, 53);
    expect_tr(S_LU, 0, 1, 54);
`endif
    wait_cyc(51);
    stat_rx_aligned = 1'b1;
    wait_cyc(60);
    stat_rx_aligned = 1'b0;
`ifdef CMAC_SEQ_DEBOUNCE_EN
    expect_tr(S_WA, 0, 1, 67);
    expect_tr(S_LU, 0, 1, 69);
`else
    expect_tr(S_WA, 0, 2, 63);
    expect_tr(S_LU, 0, 2, 69);
`endif
    wait_cyc(66);
    stat_rx_aligned = 1'b1;
    wait_cyc(80);
    gt_powergood = 1'b0;
    stat_rx_aligned = 1'b0;
`ifdef CMAC_SEQ_DEBOUNCE_EN
    expect_tr(S_RT, 0, 1, 83);
    expect_tr(S_GT, 1, 1, 84);
`else
    expect_tr(S_RT, 0, 2, 83);
    expect_tr(S_GT, 1, 2, 84);
`endif
    wait_cyc(88);
    drain();

    // Run C: one align timeout, link up, long alignment loss, reset mid WAIT_ALIGN.
    gt_powergood = 1'b1;
    stat_rx_aligned = 1'b0;
    do_reset();
    expect_tr(S_WP, 0, 0, 8);
    expect_tr(S_CR, 0, 0, 9);
    expect_tr(S_WA, 0, 0, 13);
    expect_tr(S_RT, 0, 0, 43);
    expect_tr(S_GT, 1, 0, 44);
    expect_tr(S_WP, 1, 0, 52);
    expect_tr(S_CR, 1, 0, 53);
    expect_tr(S_WA, 1, 0, 57);
    wait_cyc(60);
    stat_rx_aligned = 1'b1;
    expect_tr(S_LU, 1, 0, 63);
    wait_cyc(65);
    drain();
    check("lu_send_rfi", ctl_tx_send_rfi, 0);
    check("lu_tx_enable", ctl_tx_enable, 1);
    check("lu_link_up", link_up, 1);
    wait_cyc(70);
    stat_rx_aligned = 1'b0;
`ifdef CMAC_SEQ_DEBOUNCE_EN
    expect_tr(S_WA, 1, 1, 77);
`else
    expect_tr(S_WA, 1, 1, 73);
`endif
    wait_cyc(80);
    drain();
    check("wa_send_rfi", ctl_tx_send_rfi, 1);
    // Reset lands while in WAIT_ALIGN; powergood is also dropped for Run B.
    gt_powergood = 1'b0;
    expect_tr(S_GT, 0, 0, -1);
    do_reset();

    // Run B: powergood never rises -> three GT reset attempts, then FAIL.
    expect_tr(S_WP, 0, 0, 8);
    expect_tr(S_RT, 0, 0, 28);
    expect_tr(S_GT, 1, 0, 29);
    expect_tr(S_WP, 1, 0, 37);
    expect_tr(S_RT, 1, 0, 57);
    expect_tr(S_GT, 2, 0, 58);
    expect_tr(S_WP, 2, 0, 66);
    expect_tr(S_RT, 2, 0, 86);
    expect_tr(S_FL, 2, 0, 87);
    wait_cyc(100);
    drain();
    check("fail_seq_fail", seq_fail, 1);
    check("fail_gt_reset", gt_reset, 1);
    check("fail_core_resets", {core_tx_reset, core_rx_reset}, 2'b11);
    check("fail_retry_count", retry_count, 2);
    check("fail_state", seq_state, S_FL);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
